preg_free_list: RTL and testbench
=================================

Name: preg_free_list

Overview:
- Physical-register free-list manager for the rename stage.
- Holds the pool of unmapped physical registers as a circular FIFO.
- Grants one preg per cycle to the renamer through a valid/ready handshake, and accepts one released preg per cycle from commit.
- On reset it sequences its own initialisation: P0..P(NUM_AREGS-1) identity-mapped to x0..x31, the rest free.

Parameters:
- NUM_PREGS, 64, physical register count; power of two; FIFO depth.
- NUM_AREGS, 32, architectural register count; pregs below this start mapped.
- PREG_W, 6, preg index width, log2(NUM_PREGS).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- alloc_req  in  1  renamer requests one preg this cycle.
- alloc_ready  out  1  a free preg is available; combinational.
- alloc_preg  out  PREG_W  preg granted when alloc_req && alloc_ready; combinational FIFO head.
- free_valid  in  1  commit returns free_preg to the pool this cycle.
- free_preg  in  PREG_W  preg being released.
- free_count  out  PREG_W+1  current number of entries in the list.
- init_done  out  1  registered; high once initialisation is complete.
- err  out  1  registered, sticky until rst; illegal free detected.

Behaviour:
- Storage:
  - mem[NUM_PREGS] of PREG_W bits.
  - head and tail, PREG_W bits each, wrap modulo NUM_PREGS.
  - count, PREG_W+1 bits.
  - in_list bitmap, NUM_PREGS bits.
  - init_ctr, PREG_W+1 bits.
  - state: INIT or RUN.
- Reset (rst=1 at an edge, from any state, mid-operation included):
  - state=INIT, head=tail=0, count=0, in_list=0, init_ctr=NUM_AREGS, init_done=0, err=0.
  - mem contents are don't-care.
  - While rst=1 or state=INIT: alloc_ready=0 and alloc_preg=0.
- INIT (once per cycle, rst low):
  - mem[tail]=init_ctr, in_list[init_ctr]=1, tail++, count++, init_ctr++.
  - The edge that writes init_ctr==NUM_PREGS-1 moves state to RUN and sets init_done=1.
  - This takes NUM_PREGS-NUM_AREGS edges (32 by default).
  - In INIT, alloc_req is ignored. free_valid drops the free and sets err.
- RUN:
  - alloc_ready = (count!=0).
  - alloc_preg = mem[head] when count!=0, else 0.
- Allocation (alloc_req && alloc_ready at an edge): head++, count--, in_list[mem[head]]=0.
- Free (free_valid at an edge): accepted only if all three hold:
  - free_preg!=0 (P0 is permanently x0);
  - in_list[free_preg]==0 (not a double free);
  - count<NUM_PREGS, or an allocation fires the same edge.
- Accepted free: mem[tail]=free_preg, tail++, count++, in_list[free_preg]=1.
- Rejected free: list unchanged, err=1.
- Simultaneous alloc and accepted free: both happen, count unchanged. The freed preg enters at tail, behind existing entries.
- No bypass:
  - When count==0, a free in cycle N is not grantable in cycle N; alloc_ready rises in cycle N+1.
  - alloc_req while alloc_ready=0 has no effect; the renamer must hold the request (stall).
- free_count equals count at all times (registered value).

Test Plan:
1. Pulse rst for 1 edge, then release. init_done=0 for 31 edges and 1 after edge 32. Then free_count=32, alloc_ready=1, alloc_preg=32, err=0.
2. After init, hold alloc_req=1 for 33 cycles. Grants P32..P63 in order on 32 edges. Then alloc_ready=0, free_count=0, alloc_preg=0, and the 33rd request gets no grant.
3. From the empty state of scenario 2: free P45 with alloc_req=1 in the same cycle. No grant that cycle. Next cycle alloc_ready=1, alloc_preg=45, free_count=1.
4. With free_count=5, assert alloc_req and free_valid (P50) together. Head advances, free_count stays 5, and P50 is granted only after the 4 older entries.
5. After init, free P40 (already in list). err=1, free_count stays 32. After a new reset, free P0: err=1, count unchanged.
6. After scenario 2 with 10 grants done, assert rst for 1 cycle mid-run. alloc_ready=0, init_done=0, err=0, free_count=0. Reinit repeats scenario 1 exactly.

Source files
------------

// File: rtl/preg_free_list.sv
// Physical-register free list for rename: circular FIFO of unmapped pregs with
// self-sequenced initialisation and illegal-free detection.
module preg_free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int PREG_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    output logic              alloc_ready,
    output logic [PREG_W-1:0] alloc_preg,
    input  logic              free_valid,
    input  logic [PREG_W-1:0] free_preg,
    output logic [PREG_W:0]   free_count,
    output logic              init_done,
    output logic              err
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [PREG_W:0] DEPTH = (PREG_W+1)'(NUM_PREGS);
    localparam logic [PREG_W:0] LAST  = (PREG_W+1)'(NUM_PREGS - 1);
    localparam logic [PREG_W:0] FIRST = (PREG_W+1)'(NUM_AREGS);

    state_t               state;
    logic [PREG_W-1:0]    mem [NUM_PREGS];
    logic [PREG_W-1:0]    head, tail;
    logic [PREG_W:0]      count, init_ctr;
    logic [NUM_PREGS-1:0] in_list;

    logic              alloc_fire, free_ok, wr_en;
    logic [PREG_W-1:0] wr_data;

    always_comb begin
        alloc_ready = !rst && (state == S_RUN) && (count != '0);
        alloc_preg  = alloc_ready ? mem[head] : '0;
        alloc_fire  = alloc_req && alloc_ready;
        // in_list is sampled pre-edge, so freeing the entry being granted is a double free
        free_ok     = (state == S_RUN) && free_valid && (free_preg != '0) &&
                      !in_list[free_preg] && ((count < DEPTH) || alloc_fire);
        wr_en       = !rst && ((state == S_INIT) || free_ok);
        wr_data     = (state == S_INIT) ? init_ctr[PREG_W-1:0] : free_preg;
    end

    assign free_count = count;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[tail] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            in_list   <= '0;
            init_ctr  <= FIRST;
            init_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    in_list[init_ctr[PREG_W-1:0]] <= 1'b1;
                    tail     <= tail + 1'b1;
                    count    <= count + 1'b1;
                    init_ctr <= init_ctr + 1'b1;
                    if (free_valid)
                        err <= 1'b1;
                    if (init_ctr == LAST) begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (alloc_fire) begin
                        head              <= head + 1'b1;
                        in_list[mem[head]] <= 1'b0;
                    end
                    if (free_ok) begin
                        tail               <= tail + 1'b1;
                        in_list[free_preg] <= 1'b1;
                    end
                    if (free_valid && !free_ok)
                        err <= 1'b1;
                    if (free_ok && !alloc_fire)
                        count <= count + 1'b1;
                    else if (alloc_fire && !free_ok)
                        count <= count - 1'b1;
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_preg_free_list.sv
// Bench for preg_free_list: table of stimulus rows with constant expectations,
// plus a queue scoreboard holding the expected grant order.
module tb_preg_free_list;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alloc_req = 1'b0;
    logic       alloc_ready;
    logic [5:0] alloc_preg;
    logic       free_valid = 1'b0;
    logic [5:0] free_preg = '0;
    logic [6:0] free_count;
    logic       init_done;
    logic       err;

    preg_free_list dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_req  (alloc_req),
        .alloc_ready(alloc_ready),
        .alloc_preg (alloc_preg),
        .free_valid (free_valid),
        .free_preg  (free_preg),
        .free_count (free_count),
        .init_done  (init_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       r, q, fv;
        logic [5:0] fp;
        logic       chk;
        logic       e_rdy;
        logic [5:0] e_preg;
        logic [6:0] e_cnt;
        logic       e_err, e_done;
    } vec_t;

    vec_t vecs[$];
    int   applied = 0;
    int   miscompares = 0;

    // reference state: sb_q is the expected free-list order
    int        sb_q[$];
    bit [63:0] m_in;
    bit        m_err, m_run, m_valid;
    int        m_init;

    task automatic add(input int n, input logic r, q, fv, input logic [5:0] fp,
                       input logic c, input logic er, input logic [5:0] ep,
                       input logic [6:0] ec, input logic ee, ed);
        vecs.push_back('{n, r, q, fv, fp, c, er, ep, ec, ee, ed});
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input bit docheck);
        bit  m_rdy, fire, ok;
        @(negedge clk);
        rst = v.r; alloc_req = v.q; free_valid = v.fv; free_preg = v.fp;
        #1;
        if (docheck) begin
            check("tbl_ready", alloc_ready, v.e_rdy);
            check("tbl_preg",  alloc_preg,  v.e_preg);
            check("tbl_count", free_count,  v.e_cnt);
            check("tbl_err",   err,         v.e_err);
            check("tbl_done",  init_done,   v.e_done);
        end
        m_rdy = 1'b0;
        fire  = 1'b0;
        if (m_valid) begin
            m_rdy = !v.r && m_run && (sb_q.size() != 0);
            fire  = v.q && m_rdy;
            check("sb_ready", alloc_ready, m_rdy);
            check("sb_count", free_count, sb_q.size());
            check("sb_err",   err, m_err);
            check("sb_done",  init_done, m_run);
            if (m_rdy) check(fire ? "sb_grant" : "sb_head", alloc_preg, sb_q[0]);
            else       check("sb_preg_idle", alloc_preg, 0);
        end
        if (v.r) begin
            sb_q.delete();
            m_in = '0; m_err = 0; m_run = 0; m_init = 32; m_valid = 1;
        end else if (m_valid) begin
            if (!m_run) begin
                if (v.fv) m_err = 1;
                sb_q.push_back(m_init);
                m_in[m_init] = 1;
                if (m_init == 63) m_run = 1;
                m_init++;
            end else begin
                ok = v.fv && (v.fp != 0) && !m_in[v.fp] && ((sb_q.size() < 64) || fire);
                if (fire) begin
                    m_in[sb_q[0]] = 0;
                    void'(sb_q.pop_front());
                end
                if (ok) begin
                    sb_q.push_back(v.fp);
                    m_in[v.fp] = 1;
                end else if (v.fv) m_err = 1;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        // n  r  q  fv fp  chk rdy preg cnt err done
        add(1, 1, 0, 0, 0,  0,  0, 0,  0, 0, 0);
        add(31,0, 0, 0, 0,  1,  0, 0,  0, 0, 0);
        add(1, 0, 0, 0, 0,  1,  0, 0, 31, 0, 0);
        add(1, 0, 0, 1, 40, 1,  1, 32, 32, 0, 1);   // double free of P40
        add(1, 0, 0, 0, 0,  1,  1, 32, 32, 1, 1);
        add(1, 1, 0, 0, 0,  1,  0, 0, 32, 1, 1);
        add(32,0, 0, 0, 0,  1,  0, 0,  0, 0, 0);
        add(1, 0, 0, 1, 0,  1,  1, 32, 32, 0, 1);   // free of P0
        add(1, 0, 0, 0, 0,  1,  1, 32, 32, 1, 1);
        add(1, 1, 0, 0, 0,  1,  0, 0, 32, 1, 1);
        add(32,0, 0, 0, 0,  1,  0, 0,  0, 0, 0);
        add(33,0, 1, 0, 0,  1,  1, 32, 32, 0, 1);   // drain the pool
        add(1, 0, 0, 0, 0,  1,  0, 0,  0, 0, 1);
        add(1, 0, 1, 1, 45, 1,  0, 0,  0, 0, 1);    // no bypass when empty
        add(1, 0, 0, 0, 0,  1,  1, 45,  1, 0, 1);
        add(1, 0, 1, 0, 0,  1,  1, 45,  1, 0, 1);
        add(1, 0, 0, 1, 33, 1,  0, 0,  0, 0, 1);
        add(1, 0, 0, 1, 34, 0,  0, 0,  0, 0, 0);
        add(1, 0, 0, 1, 35, 0,  0, 0,  0, 0, 0);
        add(1, 0, 0, 1, 36, 0,  0, 0,  0, 0, 0);
        add(1, 0, 0, 1, 37, 0,  0, 0,  0, 0, 0);
        add(1, 0, 1, 1, 50, 1,  1, 33,  5, 0, 1);   // alloc + free together
        add(1, 0, 1, 0, 0,  1,  1, 34,  5, 0, 1);
        add(3, 0, 1, 0, 0,  1,  1, 35,  4, 0, 1);
        add(1, 0, 0, 0, 0,  1,  1, 50,  1, 0, 1);
        add(1, 0, 1, 0, 0,  1,  1, 50,  1, 0, 1);
        add(1, 0, 0, 0, 0,  1,  0, 0,  0, 0, 1);
        add(1, 1, 0, 0, 0,  1,  0, 0,  0, 0, 1);
        add(32,0, 0, 0, 0,  1,  0, 0,  0, 0, 0);
        add(10,0, 1, 0, 0,  1,  1, 32, 32, 0, 1);
        add(1, 1, 0, 0, 0,  1,  0, 0, 22, 0, 1);    // reset mid-run
        add(31,0, 0, 0, 0,  1,  0, 0,  0, 0, 0);
        add(1, 0, 0, 0, 0,  1,  0, 0, 31, 0, 0);
        add(1, 0, 0, 0, 0,  1,  1, 32, 32, 0, 1);
        add(1, 1, 0, 0, 0,  1,  0, 0, 32, 0, 1);
        add(1, 0, 1, 1, 5,  1,  0, 0,  0, 0, 0);    // free during init
        add(1, 0, 0, 0, 0,  1,  0, 0,  1, 1, 0);

        for (int i = 0; i < vecs.size(); i++)
            for (int k = 0; k < vecs[i].n; k++)
                step(vecs[i], vecs[i].chk && (k == 0));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
